// File: rtl/pwm_sched_pkg.sv
// Shared constants and FSM state encoding for the pattern PWM scheduler.
package pwm_sched_pkg;
    localparam int DUTY_W    = 8;
    localparam int N_REQ_MAX = 8;
    localparam int ID_W      = $clog2(N_REQ_MAX);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_FINISH    = 3'd4
    } sched_state_t;
endpackage

// File: rtl/pwm_rr_arb.sv
// Round-robin picker: the first set request at or after i_ptr, wrapping modulo N_REQ.
module pwm_rr_arb
    import pwm_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);
    int w_dist;
    int w_best;

    // Smallest circular distance from the pointer wins.
    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_best   = N_REQ;
        w_dist   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i >= int'(i_ptr)) w_dist = i - int'(i_ptr);
            else                  w_dist = i + N_REQ - int'(i_ptr);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_winner    = '0;
                o_winner[i] = 1'b1;
                o_idx       = ID_W'(i);
                o_any       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pwm_pattern_sched.sv
// Shares one pattern PWM engine among N_REQ requesters: round-robin arbitration,
// launch strobe, completion tracking and a per-job watchdog.
module pwm_pattern_sched
    import pwm_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int PAT_WIDTH   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*PAT_WIDTH-1:0] req_pat,
    input  logic [N_REQ*DUTY_W-1:0]    req_duty,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           err,
    output logic                       eng_en,
    output logic [PAT_WIDTH-1:0]       eng_pat,
    output logic [DUTY_W-1:0]          eng_duty,
    input  logic                       eng_busy,
    input  logic                       eng_valid,
    output logic                       sched_busy,
    output logic [ID_W-1:0]            cur_id
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    // Counter is cleared in the launch cycle, so this places err exactly
    // TIMEOUT_CYC cycles after the gnt/eng_en cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

    sched_state_t r_state, w_state_nxt;

    logic [ID_W-1:0]      r_ptr, r_win_idx, r_cur_id, w_arb_idx, w_ptr_nxt;
    logic [N_REQ-1:0]     r_win_oh, r_gnt, r_done, r_err, w_arb_oh;
    logic                 w_arb_any, w_launch, w_complete, w_abort, w_wd_expire;
    logic                 r_eng_en, r_busy;
    logic [PAT_WIDTH-1:0] r_pat, w_sel_pat;
    logic [DUTY_W-1:0]    r_duty, w_sel_duty;
    logic [WD_W-1:0]      r_wd;

    pwm_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_arb_oh),
        .o_idx    (w_arb_idx),
        .o_any    (w_arb_any)
    );

    always_comb begin
        w_sel_pat  = '0;
        w_sel_duty = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_oh[i]) begin
                w_sel_pat  = req_pat[i*PAT_WIDTH +: PAT_WIDTH];
                w_sel_duty = req_duty[i*DUTY_W +: DUTY_W];
            end
        end
    end

    assign w_wd_expire = (r_wd == WD_LAST);
    assign w_ptr_nxt   = (r_win_idx == ID_W'(N_REQ - 1)) ? '0 : r_win_idx + 1'b1;

    // eng_valid is checked before the watchdog so a coincident expiry still completes.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any && !eng_busy) begin
                    w_state_nxt = ST_LAUNCH;
                    w_launch    = 1'b1;
                end
            end
            ST_LAUNCH: w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY, ST_RUN: begin
                if (eng_valid) begin
                    w_state_nxt = ST_FINISH;
                    w_complete  = 1'b1;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (eng_busy) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_win_idx <= '0;
            r_win_oh  <= '0;
            r_cur_id  <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_eng_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_pat     <= '0;
            r_duty    <= '0;
            r_wd      <= '0;
        end else begin
            r_gnt    <= w_launch   ? w_arb_oh : '0;
            r_eng_en <= w_launch;
            r_done   <= w_complete ? r_win_oh : '0;
            r_err    <= w_abort    ? r_win_oh : '0;
            r_busy   <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_IDLE) r_cur_id <= '0;
            else if (w_launch)          r_cur_id <= w_arb_idx;

            if (w_launch) begin
                r_win_oh  <= w_arb_oh;
                r_win_idx <= w_arb_idx;
                r_pat     <= w_sel_pat;
                r_duty    <= w_sel_duty;
            end else if ((r_state == ST_FINISH) || w_abort) begin
                r_ptr  <= w_ptr_nxt;
                r_pat  <= '0;
                r_duty <= '0;
            end

            if (r_state == ST_LAUNCH)
                r_wd <= '0;
            else if ((r_state == ST_WAIT_BUSY) || (r_state == ST_RUN))
                r_wd <= r_wd + 1'b1;
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign eng_en     = r_eng_en;
    assign eng_pat    = r_pat;
    assign eng_duty   = r_duty;
    assign sched_busy = r_busy;
    assign cur_id     = r_cur_id;
endmodule

// File: tb/tb_pwm_pattern_sched.sv
// Directed bench for pwm_pattern_sched with a hand-driven engine model.
module tb_pwm_pattern_sched;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*PW-1:0] req_pat;
    logic [N*8-1:0]  req_duty;
    logic [N-1:0]  gnt, done, err;
    logic          eng_en;
    logic [PW-1:0] eng_pat;
    logic [7:0]    eng_duty;
    logic          eng_busy, eng_valid;
    logic          sched_busy;
    logic [2:0]    cur_id;

    int checks = 0;
    int errors = 0;

    pwm_pattern_sched #(.N_REQ(N), .PAT_WIDTH(PW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_pat(req_pat), .req_duty(req_duty),
        .gnt(gnt), .done(done), .err(err), .eng_en(eng_en), .eng_pat(eng_pat),
        .eng_duty(eng_duty), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .sched_busy(sched_busy), .cur_id(cur_id)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int limit, output int cyc);
        cyc = 0;
        while (gnt == '0 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    // Engine model: busy for n cycles, then an end-of-pattern pulse; returns in the done cycle.
    task automatic engine_finish(input int n);
        eng_busy = 1'b1;
        repeat (n) tick();
        eng_valid = 1'b1;
        eng_busy  = 1'b0;
        tick();
        eng_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        eng_busy = 1'b0;
        eng_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_pat = '0; req_duty = '0;
        eng_busy = 1'b0; eng_valid = 1'b0;
        tick(); tick();
        checks++; if ({gnt, done, err} !== 12'h000) begin errors++; $display("FAIL reset_pulses got %h exp 000", {gnt, done, err}); end
        checks++; if (eng_en !== 1'b0) begin errors++; $display("FAIL reset_eng_en got %b exp 0", eng_en); end
        checks++; if ({eng_pat, eng_duty} !== 16'h0000) begin errors++; $display("FAIL reset_cfg got %h exp 0000", {eng_pat, eng_duty}); end
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", sched_busy); end
        checks++; if (cur_id !== 3'd0) begin errors++; $display("FAIL reset_cur_id got %0d exp 0", cur_id); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int c;
        req_pat[7:0] = 8'hA5; req_duty[7:0] = 8'd3;
        req = 4'b0001;
        wait_gnt(10, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", c); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
        checks++; if (eng_en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", eng_en); end
        checks++; if (eng_pat !== 8'hA5) begin errors++; $display("FAIL single_pat got %h exp a5", eng_pat); end
        checks++; if (eng_duty !== 8'd3) begin errors++; $display("FAIL single_duty got %0d exp 3", eng_duty); end
        checks++; if (sched_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", sched_busy); end
        req = '0; eng_busy = 1'b1;
        tick();
        checks++; if ({gnt, eng_en} !== 5'b0) begin errors++; $display("FAIL single_gnt_pulse got %b exp 00000", {gnt, eng_en}); end
        req_pat[7:0] = 8'h00; req_duty[7:0] = 8'd99; req = 4'b1111;
        repeat (30) tick();
        req = '0;
        checks++; if ({eng_pat, eng_duty} !== {8'hA5, 8'd3}) begin errors++; $display("FAIL single_hold got %h exp a503", {eng_pat, eng_duty}); end
        checks++; if ({gnt, done} !== 8'h00) begin errors++; $display("FAIL single_quiet got %h exp 00", {gnt, done}); end
        eng_valid = 1'b1; eng_busy = 1'b0;
        tick();
        eng_valid = 1'b0;
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done got %b exp 0001", done); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL single_err got %b exp 0000", err); end
        tick();
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse got %b exp 0000", done); end
        checks++; if ({sched_busy, eng_pat, eng_duty, cur_id} !== 20'h0) begin errors++; $display("FAIL single_idle got %h exp 0", {sched_busy, eng_pat, eng_duty, cur_id}); end
    endtask

    task automatic test_drop_before_gnt();
        int seen;
        seen = 0;
        eng_busy = 1'b1; req = 4'b0001;
        repeat (3) begin tick(); if (gnt != '0) seen++; end
        req = '0; eng_busy = 1'b0;
        repeat (4) begin tick(); if (gnt != '0 || eng_en) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL drop_no_gnt got %0d pulses exp 0", seen); end
    endtask

    task automatic test_fairness();
        int c;
        logic [N-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < N; i++) req_pat[i*PW +: PW] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            wait_gnt(10, c);
            if (k > 0) begin
                checks++; if (c !== 2) begin errors++; $display("FAIL fair_gap%0d got %0d exp 2", k, c); end
            end
            checks++; if (gnt !== exp_oh) begin errors++; $display("FAIL fair_gnt%0d got %b exp %b", k, gnt, exp_oh); end
            checks++; if (eng_pat !== 8'h10 + 8'(k % 4)) begin errors++; $display("FAIL fair_pat%0d got %h exp %h", k, eng_pat, 8'h10 + 8'(k % 4)); end
            if (k == 4) req = '0;
            engine_finish(3);
            checks++; if (done !== exp_oh) begin errors++; $display("FAIL fair_done%0d got %b exp %b", k, done, exp_oh); end
        end
        tick();
    endtask

    task automatic test_ptr_wrap();
        int c;
        req = 4'b1000;
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3 got %b exp 1000", gnt); end
        req = '0;
        engine_finish(2);
        req = 4'b1001;
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_first got %b exp 0001", gnt); end
        req = 4'b1000;
        engine_finish(2);
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_second got %b exp 1000", gnt); end
        checks++; if (cur_id !== 3'd3) begin errors++; $display("FAIL wrap_cur_id got %0d exp 3", cur_id); end
        req = '0;
        engine_finish(2);
        req = 4'b0100;
        wait_gnt(10, c);
        req = '0;
        engine_finish(2);
        req = 4'b0011;
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_past_end got %b exp 0001", gnt); end
        req = '0;
        engine_finish(2);
        tick();
    endtask

    task automatic test_watchdog();
        int c, dn;
        req = 4'b0010;
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wd_gnt got %b exp 0010", gnt); end
        req = '0; eng_busy = 1'b1;
        c = 0; dn = 0;
        while (err == '0 && c < 200) begin
            tick();
            c++;
            if (done != '0) dn++;
        end
        checks++; if (c !== TO) begin errors++; $display("FAIL wd_cycles got %0d exp %0d", c, TO); end
        checks++; if (err !== 4'b0010) begin errors++; $display("FAIL wd_err got %b exp 0010", err); end
        checks++; if (dn !== 0) begin errors++; $display("FAIL wd_no_done got %0d exp 0", dn); end
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL wd_idle got %b exp 0", sched_busy); end
        eng_busy = 1'b0;
        tick();
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL wd_err_pulse got %b exp 0000", err); end
        req = 4'b0001;
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wd_next_gnt got %b exp 0001", gnt); end
        req = '0;
        engine_finish(2);
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL wd_next_done got %b exp 0001", done); end
        tick();
    endtask

    task automatic test_valid_vs_timeout();
        int c;
        req = 4'b0100;
        wait_gnt(10, c);
        req = '0; eng_busy = 1'b1;
        repeat (TO - 1) tick();
        eng_valid = 1'b1; eng_busy = 1'b0;
        tick();
        eng_valid = 1'b0;
        checks++; if (done !== 4'b0100) begin errors++; $display("FAIL race_done got %b exp 0100", done); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL race_err got %b exp 0000", err); end
        tick();
        checks++; if ({done, err} !== 8'h00) begin errors++; $display("FAIL race_after got %h exp 00", {done, err}); end
    endtask

    task automatic test_reset_mid_run();
        int c, seen;
        req_pat[1*PW +: PW] = 8'h3C; req_duty[1*8 +: 8] = 8'd7;
        req = 4'b0010;
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_gnt got %b exp 0010", gnt); end
        req = '0; eng_busy = 1'b1;
        repeat (5) tick();
        checks++; if ({sched_busy, eng_pat} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL rmid_running got %h exp 13c", {sched_busy, eng_pat}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({gnt, done, err, eng_en} !== 13'h0) begin errors++; $display("FAIL rmid_pulses got %h exp 0", {gnt, done, err, eng_en}); end
        checks++; if ({eng_pat, eng_duty} !== 16'h0) begin errors++; $display("FAIL rmid_cfg got %h exp 0", {eng_pat, eng_duty}); end
        checks++; if ({sched_busy, cur_id} !== 4'h0) begin errors++; $display("FAIL rmid_state got %h exp 0", {sched_busy, cur_id}); end
        tick();
        rst = 1'b0; eng_busy = 1'b0;
        seen = 0;
        repeat (4) begin tick(); if (done != '0 || err != '0) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_silent got %0d exp 0", seen); end
        req = 4'b1100;
        wait_gnt(10, c);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_from0 got %b exp 0100", gnt); end
        checks++; if (cur_id !== 3'd2) begin errors++; $display("FAIL rmid_cur_id got %0d exp 2", cur_id); end
        req = '0;
        engine_finish(2);
        checks++; if (done !== 4'b0100) begin errors++; $display("FAIL rmid_done got %b exp 0100", done); end
        tick();
    endtask

    task automatic test_duty_zero();
        int c, ens, dns;
        req_pat[7:0] = 8'h01; req_duty[7:0] = 8'd0;
        req = 4'b0001;
        wait_gnt(10, c);
        checks++; if ({gnt, eng_pat, eng_duty} !== {4'b0001, 8'h01, 8'h00}) begin errors++; $display("FAIL zero_launch got %h exp 10100", {gnt, eng_pat, eng_duty}); end
        ens = int'(eng_en); dns = 0;
        req = '0; eng_busy = 1'b1;
        repeat (4) begin tick(); ens += int'(eng_en); dns += (done != '0) ? 1 : 0; end
        eng_valid = 1'b1; eng_busy = 1'b0;
        tick();
        eng_valid = 1'b0;
        ens += int'(eng_en); dns += (done == 4'b0001) ? 1 : 0;
        repeat (4) begin tick(); ens += int'(eng_en); dns += (done != '0) ? 1 : 0; end
        checks++; if (ens !== 1) begin errors++; $display("FAIL zero_en_count got %0d exp 1", ens); end
        checks++; if (dns !== 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", dns); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_drop_before_gnt();
        test_fairness();
        test_ptr_wrap();
        test_watchdog();
        test_valid_vs_timeout();
        test_reset_mid_run();
        test_duty_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_pattern_sched.md
PWM_PATTERN_SCHED -- requirements
Module: pwm_pattern_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one pattern PWM engine (2..8).
REQ-002 Parameter PAT_WIDTH, default 8, pattern register width passed to the engine.
REQ-003 Parameter TIMEOUT_CYC, default 4096, watchdog limit in clk cycles per launched job.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  N_REQ  per-requester level request, held until its gnt bit pulses.
REQ-007 req_pat  in  N_REQ*PAT_WIDTH  per-requester pattern, slice i = requester i.
REQ-008 req_duty  in  N_REQ*8  per-requester duty_num, slice i = requester i.
REQ-009 gnt  out  N_REQ  one-hot, one-cycle pulse: job accepted, config latched.
REQ-010 done  out  N_REQ  one-hot, one-cycle pulse: job completed normally.
REQ-011 err  out  N_REQ  one-hot, one-cycle pulse: job aborted by watchdog.
REQ-012 eng_en  out  1  engine start strobe, one cycle.
REQ-013 eng_pat  out  PAT_WIDTH  engine pattern, stable for whole job.
REQ-014 eng_duty  out  8  engine duty_num, stable for whole job.
REQ-015 eng_busy  in  1  engine busy.
REQ-016 eng_valid  in  1  engine end-of-pattern pulse.
REQ-017 sched_busy  out  1  high in every state except IDLE.
REQ-018 cur_id  out  3  index of requester currently owning the engine; 0 when idle.

Function
REQ-019 FSM states IDLE, LAUNCH, WAIT_BUSY, RUN, FINISH; all outputs registered.
REQ-020 IDLE: if any req bit high and eng_busy low, select winner round-robin, latch its pat/duty to eng_pat/eng_duty, go LAUNCH; else stay.
REQ-021 Round-robin: winner = first set req bit at index ptr, ptr+1, ... wrapping modulo N_REQ; ptr resets to 0.
REQ-022 LAUNCH (exactly one cycle): gnt[winner]=1, eng_en=1; next state WAIT_BUSY.
REQ-023 WAIT_BUSY: stay until eng_busy=1, then RUN; eng_valid seen here also completes the job (go FINISH).
REQ-024 RUN: on eng_valid=1 go FINISH; eng_busy falling without eng_valid is not completion.
REQ-025 FINISH (one cycle): done[winner]=1, ptr <= (winner+1) mod N_REQ, eng_pat/eng_duty cleared to 0, next IDLE.
REQ-026 Latency: req sampled at edge k in IDLE -> gnt/eng_en high in cycle k+1; eng_valid sampled at edge m -> done high in cycle m+1.
REQ-027 Minimum one IDLE cycle between FINISH and next LAUNCH; back-to-back requester sees gnt 2 cycles after previous done.
REQ-028 Watchdog counter cleared on LAUNCH, increments in WAIT_BUSY and RUN; on reaching TIMEOUT_CYC: err[winner]=1, ptr advanced as REQ-025, go IDLE, done not asserted.
REQ-029 req bit dropped before gnt: not served, no pulse; req held high after done: re-arbitrated normally.
REQ-030 duty 0 and all-zero pattern are valid jobs; no special casing.
REQ-031 Simultaneous eng_valid and watchdog expiry: eng_valid wins, done asserted, no err.
REQ-032 req changes during a job ignored; eng_pat/eng_duty never change between LAUNCH and FINISH.

Reset
REQ-033 rst asserted at any time: state IDLE, ptr 0, watchdog 0, gnt/done/err/eng_en 0, eng_pat/eng_duty 0, sched_busy 0, cur_id 0, immediately (async).
REQ-034 Reset mid-job issues no done/err; first job after release arbitrates from index 0.

Structure
REQ-035 Package pwm_sched_pkg holds FSM state encodings, duty width constant (8) and N_REQ max (8).
REQ-036 Round-robin selection in sub-module pwm_rr_arb (inputs req, ptr; outputs one-hot winner, index, any).

Verification
REQ-037 Single: req=0001, pat=8'hA5, duty=3 -> gnt[0] next cycle, eng_pat=8'hA5 held, done[0] one cycle after eng_valid (~32 engine cycles).
REQ-038 Fairness: req=1111 held continuously -> grant order 0,1,2,3,0; each done precedes next gnt by 2 cycles.
REQ-039 Pointer wrap: after job on requester 3, req=1001 -> requester 0 granted before 3.
REQ-040 Watchdog: TIMEOUT_CYC=64, engine model never asserts eng_valid -> err[i] at cycle 64 after LAUNCH, no done, next request served.
REQ-041 Reset mid-RUN: rst pulsed -> all outputs 0 same cycle, no done/err, subsequent req=0100 granted normally.
REQ-042 duty=0, pat=8'h01 -> job completes, done pulses once, eng_en pulsed exactly once.
